aes_job_scheduler: RTL and testbench



---
 rtl/aes_job_scheduler_pkg.sv | 28 ++
 rtl/aes_job_scheduler_if.sv | 45 ++++
 rtl/aes_job_scheduler_rr_arbiter.sv | 34 +++
 rtl/aes_job_scheduler.sv | 142 ++++++++++++++
 tb/tb_aes_job_scheduler.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_job_scheduler_pkg.sv
// Shared types and constants for the AES job scheduler slice: FSM state
// encoding, AES block/key widths and a constant-evaluable clog2 helper.
package aes_sched_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/aes_job_scheduler_if.sv
// Bundle of the requester, core and response handshakes around the
// scheduler. The scheduler takes the master view; the surrounding
// system (requesters, AES core, response sink) takes the slave view.
interface aes_job_scheduler_if
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    // Requester side
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*AES_BLOCK_W-1:0] req_block;
    logic [NUM_REQ*AES_KEY_W-1:0]   req_key;

    // AES core side
    logic                   core_start;
    logic [AES_BLOCK_W-1:0] core_block;
    logic [AES_KEY_W-1:0]   core_key;
    logic                   core_done;
    logic [AES_BLOCK_W-1:0] core_result;

    // Response side
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [AES_BLOCK_W-1:0] rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_err;

    // Status
    logic                   busy;

    modport master (
        input  req_valid, req_block, req_key, core_done, core_result, rsp_ready,
        output req_ready, core_start, core_block, core_key,
        output rsp_valid, rsp_data, rsp_id, rsp_err, busy
    );

    modport slave (
        output req_valid, req_block, req_key, core_done, core_result, rsp_ready,
        input  req_ready, core_start, core_block, core_key,
        input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
    );

endinterface

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // Scan NUM_REQ slots starting at the pointer; the first hit wins.
    always_comb begin : pick
        int idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES-128 core among NUM_REQ requesters.
// Accepts {plaintext, key} jobs, pulses core_start, waits for core_done and
// returns the ciphertext tagged with the owner's ID. One job in flight.
// Optional feature: define AES_SCHED_TIMEOUT_EN to add a WAIT watchdog that
// ends a job after TIMEOUT_CYCLES cycles with rsp_err=1 and rsp_data=0.
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic                 clk,
    input logic                 rst,
    aes_job_scheduler_if.master bus
);

    sched_state_e           state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        next_ptr;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [ID_W-1:0]        arb_id;
    logic                   arb_any;

    logic [AES_BLOCK_W-1:0] sel_block;
    logic [AES_KEY_W-1:0]   sel_key;

    logic                   core_start_q;
    logic [AES_BLOCK_W-1:0] core_block_q;
    logic [AES_KEY_W-1:0]   core_key_q;
    logic                   rsp_valid_q;
    logic [AES_BLOCK_W-1:0] rsp_data_q;
    logic [ID_W-1:0]        rsp_id_q;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]        wait_cnt;
    logic                   rsp_err_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .id     (arb_id),
        .any    (arb_any)
    );

    assign sel_block = bus.req_block[int'(arb_id)*AES_BLOCK_W +: AES_BLOCK_W];
    assign sel_key   = bus.req_key[int'(arb_id)*AES_KEY_W +: AES_KEY_W];

    // Pointer moves one past the served requester; explicit top compare
    // keeps the wrap correct when NUM_REQ is not a power of two.
    assign next_ptr = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);

    // Grant is visible combinationally only while idle; accept happens on the
    // edge where req_valid and req_ready are both high.
    assign bus.req_ready  = (state == IDLE) ? arb_grant : '0;
    assign bus.core_start = core_start_q;
    assign bus.core_block = core_block_q;
    assign bus.core_key   = core_key_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = (state != IDLE);
`ifdef AES_SCHED_TIMEOUT_EN
    assign bus.rsp_err    = rsp_err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif

    // Job FSM: accept -> start pulse -> wait for core -> hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            core_start_q <= 1'b0;
            core_block_q <= '0;
            core_key_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
            wait_cnt     <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        core_block_q <= sel_block;
                        core_key_q   <= sel_key;
                        rsp_id_q     <= arb_id;
                        core_start_q <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
`ifdef AES_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    // A done in the timeout cycle still counts as success.
                    if (bus.core_done) begin
                        rsp_data_q  <= bus.core_result;
                        rsp_valid_q <= 1'b1;
`ifdef AES_SCHED_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef AES_SCHED_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed, table-driven bench for aes_job_scheduler with NUM_REQ=4.
// The bench plays the AES core itself, answering core_start after a
// per-row number of WAIT cycles. Timeout rows exist only when
// AES_SCHED_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16 then).
module tb_aes_job_scheduler;
    import aes_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef AES_SCHED_TIMEOUT_EN
    localparam int TO_CYC  = 16;
`else
    localparam int TO_CYC  = 1023;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [3:0]   mask;
        int           exp_id;
        int           dly;
        logic [127:0] res;
        int           hold;
        bit           do_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_job_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

    aes_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_starts = 0;

    logic [127:0] blk [NUM_REQ];
    logic [127:0] key [NUM_REQ];
    vec_t         vecs [12];
    int           n_vec;

    // Count start pulses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.core_start === 1'b1) n_starts++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete job; entered and left just after a falling edge.
    task automatic run_job(input logic [3:0] mask, input int exp_id, input int dly,
                           input logic [127:0] res, input int hold, input bit do_done);
        int           st0;
        logic [127:0] exp_data;
        logic [3:0]   exp_grant;
        exp_data  = do_done ? res : '0;
        exp_grant = 4'b0001 << exp_id;
        st0 = n_starts;
        bus.req_valid = mask;
        #1;
        chk("grant", bus.req_ready, exp_grant);
        @(posedge clk);
        @(negedge clk);
        chk("start_pulse", bus.core_start, 1'b1);
        chk("busy_start", bus.busy, 1'b1);
        chk("core_block", bus.core_block, blk[exp_id]);
        chk("core_key", bus.core_key, key[exp_id]);
        chk("ready_start", bus.req_ready, 4'b0000);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("start_low", bus.core_start, 1'b0);
            chk("no_rsp_wait", bus.rsp_valid, 1'b0);
            chk("ready_wait", bus.req_ready, 4'b0000);
        end
        if (do_done) begin
            bus.core_done   = 1'b1;
            bus.core_result = res;
        end
        @(posedge clk);
        @(negedge clk);
        bus.core_done   = 1'b0;
        bus.core_result = ~res;
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_id", bus.rsp_id, exp_id);
        chk("rsp_err", bus.rsp_err, !do_done);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (k == 0) bus.core_done = 1'b1;   // stray done while in RESP
            @(negedge clk);
            bus.core_done = 1'b0;
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_data", bus.rsp_data, exp_data);
            chk("hold_id", bus.rsp_id, exp_id);
            chk("hold_ready", bus.req_ready, 4'b0000);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_done", bus.rsp_valid, 1'b0);
        chk("start_count", n_starts - st0, 1);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            blk[i] = {4{32'(32'hB10C_0000 + i)}};
            key[i] = {4{32'(32'h4B45_0000 + i)}};
        end
        blk[2] = FIPS_PT;
        key[2] = FIPS_KEY;

        //            mask     id dly result                             hold done
        vecs[0] = '{4'b1111, 0, 3, {4{32'hC1F0_0000}}, 0,  1'b1};
        vecs[1] = '{4'b1111, 1, 1, {4{32'hC1F0_0001}}, 20, 1'b1};
        vecs[2] = '{4'b1111, 2, 2, {4{32'hC1F0_0002}}, 0,  1'b1};
        vecs[3] = '{4'b1111, 3, 5, {4{32'hC1F0_0003}}, 1,  1'b1};
        vecs[4] = '{4'b1111, 0, 1, {4{32'hC1F0_0004}}, 0,  1'b1};
        vecs[5] = '{4'b0011, 1, 4, {4{32'hC1F0_0005}}, 2,  1'b1};
        vecs[6] = '{4'b0011, 0, 1, {4{32'hC1F0_0006}}, 0,  1'b1};
        vecs[7] = '{4'b1000, 3, 2, {4{32'hC1F0_0007}}, 0,  1'b1};
        vecs[8] = '{4'b0101, 0, 1, {4{32'hC1F0_0008}}, 0,  1'b1};
        vecs[9] = '{4'b0101, 2, 3, {4{32'hC1F0_0009}}, 0,  1'b1};
        n_vec = 10;
`ifdef AES_SCHED_TIMEOUT_EN
        vecs[10] = '{4'b0010, 1, 16, {4{32'hDEAD_0000}}, 0, 1'b0};
        vecs[11] = '{4'b0010, 1, 15, {4{32'hC1F0_000B}}, 0, 1'b1};
        n_vec = 12;
`endif

        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        bus.rsp_ready   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_block[128*i +: 128] = blk[i];
            bus.req_key[128*i +: 128]   = key[i];
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", bus.req_ready, 4'b0000);
        chk("rst_start", bus.core_start, 1'b0);
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_err", bus.rsp_err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_block", bus.core_block, 128'h0);
        chk("rst_key", bus.core_key, 128'h0);
        chk("rst_data", bus.rsp_data, 128'h0);
        chk("rst_id", bus.rsp_id, 2'd0);
        rst = 1'b0;

        // Stray core_done while idle with nothing requested
        bus.core_done   = 1'b1;
        bus.core_result = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        @(negedge clk);
        bus.core_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", bus.busy, 1'b0);
        chk("idle_done_valid", bus.rsp_valid, 1'b0);
        chk("idle_done_data", bus.rsp_data, 128'h0);
        chk("idle_ready", bus.req_ready, 4'b0000);

        // FIPS-197 single job from requester 2, 50-cycle core
        run_job(4'b0100, 2, 50, FIPS_CT, 0, 1'b1);
        bus.req_valid = '0;

        // Reset in WAIT: pointer is 3 here, so requester 3 wins first
        bus.req_valid = 4'b1111;
        #1;
        chk("pre_rst_grant", bus.req_ready, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_start", bus.core_start, 1'b0);
        chk("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_block", bus.core_block, 128'h0);
        chk("mid_rst_key", bus.core_key, 128'h0);
        chk("mid_rst_data", bus.rsp_data, 128'h0);
        chk("mid_rst_id", bus.rsp_id, 2'd0);
        chk("mid_rst_err", bus.rsp_err, 1'b0);
        chk("mid_rst_ptr", bus.req_ready, 4'b0001);
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.core_done   = 1'b1;           // late answer for the aborted job
        bus.core_result = {4{32'hABAD_0000}};
        @(negedge clk);
        bus.core_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid, 1'b0);
            chk("abort_busy", bus.busy, 1'b0);
        end
        chk("abort_data", bus.rsp_data, 128'h0);

        // Table rows: round-robin order, backpressure, masks, timeouts
        for (int i = 0; i < n_vec; i++) begin
            run_job(vecs[i].mask, vecs[i].exp_id, vecs[i].dly,
                    vecs[i].res, vecs[i].hold, vecs[i].do_done);
        end

        bus.req_valid = '0;
        @(negedge clk);
        chk("final_busy", bus.busy, 1'b0);
        chk("final_ready", bus.req_ready, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
